// File: rtl/ultrasonido_pkg.sv
// Shared constants and FSM encoding for the ultrasonic ranging path (trigger and echo timing).
package ultrasonido_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int US_PER_CM       = 58;
  localparam int TIMEOUT_US_DEF  = 38000;
  localparam int CLKS_PER_US_DEF = 100;
  localparam int TRIG_US         = 10;

  // Echo glitch filter: level must hold this many samples before it is accepted.
  localparam int FILT_LEN = 16;
  localparam int FILT_W   = $clog2(FILT_LEN);

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Echo synchronizer and edge detector; registered rise/fall pulses, 3 clk after the pin (+16 with ECHO_FILTER_EN).
// No backpressure: edges are single-cycle pulses; ECHO_FILTER_EN inserts a 16-sample glitch filter.
module echo_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic echo,
  output logic rise,
  output logic fall
);
  import ultrasonido_pkg::*;

  logic s1, s2, lvl, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= echo;
      s2 <= s1;
    end
  end

`ifdef ECHO_FILTER_EN
  logic [FILT_W-1:0] fcnt;
  logic              filt;

  // Counts consecutive samples disagreeing with the filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FILT_W'(FILT_LEN - 1)) begin
      fcnt <= '0;
      filt <= s2;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= lvl;
      rise <= lvl & ~prev;
      fall <= ~lvl & prev;
    end
  end

endmodule

// File: rtl/medidor_eco_ultrasonido.sv
// Times the ultrasonic echo pulse and converts its width to centimetres; one valid or timeout per start.
// Result 4 clk after the pin falls; starts while busy or in the result cycle are dropped (ECHO_FILTER_EN optional).
module medidor_eco_ultrasonido #(
  parameter int CLKS_PER_US = ultrasonido_pkg::CLKS_PER_US_DEF,
  parameter int US_PER_CM   = ultrasonido_pkg::US_PER_CM,
  parameter int TIMEOUT_US  = ultrasonido_pkg::TIMEOUT_US_DEF,
  parameter int CM_W        = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            echo,
  output logic            busy,
  output logic [CM_W-1:0] dist_cm,
  output logic            valid,
  output logic            timeout
);
  import ultrasonido_pkg::*;

  localparam int PRE_W = cnt_w(CLKS_PER_US);
  localparam int SUB_W = cnt_w(US_PER_CM);
  localparam int TMO_W = cnt_w(TIMEOUT_US + 1);

  state_t state, state_nxt;

  logic rise, fall;
  logic clr_all, clr_width, latch, set_tmo, cnt_en;
  logic us_tick, sub_wrap, tmo_hit, tmo_flag;

  logic [PRE_W-1:0] pre, pre_nxt;
  logic [SUB_W-1:0] sub, sub_nxt;
  logic [TMO_W-1:0] tmo_us, tmo_nxt;
  logic [CM_W-1:0]  cm_cnt, cm_nxt;

  echo_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .echo  (echo),
    .rise  (rise),
    .fall  (fall)
  );

  assign us_tick  = (pre == PRE_W'(CLKS_PER_US - 1));
  assign pre_nxt  = us_tick ? '0 : pre + 1'b1;
  assign tmo_hit  = (tmo_us == TMO_W'(TIMEOUT_US));
  assign tmo_nxt  = (us_tick && !tmo_hit) ? tmo_us + 1'b1 : tmo_us;
  assign sub_wrap = us_tick && (sub == SUB_W'(US_PER_CM - 1));
  assign sub_nxt  = !us_tick ? sub : (sub_wrap ? '0 : sub + 1'b1);
  // Includes the tick landing on the fall cycle so the result is floor(width/US_PER_CM).
  assign cm_nxt   = (sub_wrap && (cm_cnt != '1)) ? cm_cnt + 1'b1 : cm_cnt;
  assign cnt_en   = (state == WAIT_HI) || (state == MEASURE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_all   = 1'b0;
    clr_width = 1'b0;
    latch     = 1'b0;
    set_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_HI;
          clr_all   = 1'b1;
        end
      end
      WAIT_HI: begin
        if (rise) begin
          state_nxt = MEASURE;
          clr_width = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          set_tmo   = 1'b1;
        end
      end
      MEASURE: begin
        // A fall coinciding with the timeout still yields a measurement.
        if (fall) begin
          state_nxt = DONE;
          latch     = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          set_tmo   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre      <= '0;
      sub      <= '0;
      tmo_us   <= '0;
      cm_cnt   <= '0;
      dist_cm  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (clr_all) begin
        pre    <= '0;
        sub    <= '0;
        tmo_us <= '0;
        cm_cnt <= '0;
      end else if (clr_width) begin
        pre    <= '0;
        sub    <= '0;
        tmo_us <= tmo_nxt;
      end else if (cnt_en) begin
        pre    <= pre_nxt;
        tmo_us <= tmo_nxt;
        if (state == MEASURE) begin
          sub    <= sub_nxt;
          cm_cnt <= cm_nxt;
        end
      end
      if (latch) dist_cm <= cm_nxt;
      if (clr_all)      tmo_flag <= 1'b0;
      else if (set_tmo) tmo_flag <= 1'b1;
    end
  end

  assign busy    = (state != IDLE);
  assign valid   = (state == DONE) && !tmo_flag;
  assign timeout = (state == DONE) && tmo_flag;

endmodule

// File: tb/tb_medidor_eco_ultrasonido.sv
// Directed bench for the echo ranging block, run with a short microsecond and timeout for sim speed.
module tb_medidor_eco_ultrasonido;

  localparam int C   = 4;
  localparam int UPC = 58;
  localparam int TMO = 3000;
  localparam int CMW = 9;

  logic           clk = 1'b0;
  logic           reset, start, echo;
  logic           busy, valid, timeout;
  logic [CMW-1:0] dist_cm;

  medidor_eco_ultrasonido #(
    .CLKS_PER_US (C),
    .US_PER_CM   (UPC),
    .TIMEOUT_US  (TMO),
    .CM_W        (CMW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .echo    (echo),
    .busy    (busy),
    .dist_cm (dist_cm),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;
  int vcnt    = 0;
  int tcnt    = 0;

  always @(negedge clk) begin
    if (valid)   vcnt++;
    if (timeout) tcnt++;
  end

  typedef struct {
    int pre_us;
    int high_us;
    int exp_cm;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int v, output int t, output int waited);
    v = 0;
    t = 0;
    waited = 0;
    while (waited < budget && v == 0 && t == 0) begin
      @(negedge clk);
      waited++;
      v = int'(valid);
      t = int'(timeout);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t vv);
    int v0, t0, gv, gt, w;
    v0 = vcnt;
    t0 = tcnt;
    pulse_start();
    @(negedge clk);
    check($sformatf("vec%0d busy_after_start", idx), int'(busy), 1);
    cyc(vv.pre_us * C - 1);
    echo = 1'b1;
    cyc(vv.high_us * C);
    echo = 1'b0;
    wait_result(30, gv, gt, w);
    check($sformatf("vec%0d valid_seen", idx), gv, 1);
    check($sformatf("vec%0d busy_in_done", idx), int'(busy), 1);
    check($sformatf("vec%0d dist_cm", idx), int'(dist_cm), vv.exp_cm);
    @(negedge clk);
    check($sformatf("vec%0d busy_after_done", idx), int'(busy), 0);
    cyc(20);
    check($sformatf("vec%0d valid_count", idx), vcnt - v0, 1);
    check($sformatf("vec%0d timeout_count", idx), tcnt - t0, 0);
  endtask

  initial begin
    int bad, v0, t0, gv, gt, w, dist_before;

    vecs[0] = '{pre_us: 500, high_us: 580, exp_cm: 10};
    vecs[1] = '{pre_us: 20,  high_us: 57,  exp_cm: 0};
    vecs[2] = '{pre_us: 20,  high_us: 116, exp_cm: 2};
    vecs[3] = '{pre_us: 10,  high_us: 58,  exp_cm: 1};
    vecs[4] = '{pre_us: 10,  high_us: 115, exp_cm: 1};

    // Reset held with echo toggling and a start request.
    reset = 1'b1;
    start = 1'b0;
    echo  = 1'b0;
    bad   = 0;
    for (int i = 0; i < 400; i++) begin
      echo  = ((i / 7) % 2) == 1;
      start = (i == 100);
      @(negedge clk);
      if (busy || valid || timeout || dist_cm != '0) bad++;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    start = 1'b0;
    echo  = 1'b0;
    check("reset_outputs_quiet", bad, 0);
    cyc(10);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_dist", int'(dist_cm), 0);
    check("reset_no_pulses", vcnt + tcnt, 0);
    cyc(1);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Echo never rises: timeout, dist held.
    dist_before = int'(dist_cm);
    v0 = vcnt;
    t0 = tcnt;
    pulse_start();
    wait_result(TMO * C + 50, gv, gt, w);
    check("tmo_seen", gt, 1);
    check("tmo_no_valid_pulse", gv, 0);
    check("tmo_timing_in_window", int'(w >= TMO * C && w <= TMO * C + 4), 1);
    check("tmo_dist_held", int'(dist_cm), dist_before);
    cyc(20);
    check("tmo_valid_count", vcnt - v0, 0);
    check("tmo_timeout_count", tcnt - t0, 1);

    // Echo already high at start; only the fresh rise counts; mid-measure start ignored.
    echo = 1'b1;
    cyc(10);
    v0 = vcnt;
    t0 = tcnt;
    pulse_start();
    cyc(100 * C);
    echo = 1'b0;
    cyc(100 * C);
    echo = 1'b1;
    cyc(100 * C);
    pulse_start();
    cyc(1060 * C);
    echo = 1'b0;
    wait_result(30, gv, gt, w);
    check("hi_start_valid", gv, 1);
    check("hi_start_dist", int'(dist_cm), 20);
    @(negedge clk);
    check("hi_start_busy_after", int'(busy), 0);
    cyc(40);
    check("hi_start_one_result", (vcnt - v0) + (tcnt - t0), 1);

    // Reset in the middle of MEASURE.
    v0 = vcnt;
    t0 = tcnt;
    pulse_start();
    cyc(20 * C);
    echo = 1'b1;
    cyc(200 * C);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", int'(busy), 0);
    check("midreset_dist", int'(dist_cm), 0);
    cyc(50 * C);
    echo = 1'b0;
    cyc(100);
    check("midreset_no_pulses", (vcnt - v0) + (tcnt - t0), 0);
    check("midreset_idle", int'(busy), 0);

`ifdef ECHO_FILTER_EN
    // Short glitch in WAIT_HI must not start a measurement.
    v0 = vcnt;
    pulse_start();
    cyc(10 * C);
    echo = 1'b1;
    cyc(10);
    echo = 1'b0;
    cyc(20 * C);
    echo = 1'b1;
    cyc(116 * C);
    echo = 1'b0;
    wait_result(60, gv, gt, w);
    check("filt_valid", gv, 1);
    check("filt_dist", int'(dist_cm), 2);
    cyc(20);
    check("filt_one_valid", vcnt - v0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
